// File: rtl/pipeline_hazard_unit_if.sv
// Pipeline hazard unit bus: the pipeline drives stage register addresses and
// control bits (master). The hazard unit returns forwarding selects, hold/flush
// controls, interrupt-entry strobes and the stall count (slave).
//   Pipeline -> unit : id_rs1/2, id_use_rs1/2, ex_rs1/2, ex_rd, ex_wb, ex_mem_read,
//                      mem_rd, mem_wb, wb_rd, wb_wb, branch_taken, interrupt
//   Unit -> pipeline : fwd_sel1/2, pc_hold, ifid_hold, idex_bubble, flush_ifid,
//                      int_push_pc, int_push_flags, int_vector_load,
//                      int_ret_branch, int_busy, stall_count
interface pipeline_hazard_unit_if #(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned STALL_CNT_W = 16
);
  logic [REG_AW-1:0]      id_rs1;
  logic [REG_AW-1:0]      id_rs2;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic [REG_AW-1:0]      ex_rs1;
  logic [REG_AW-1:0]      ex_rs2;
  logic [REG_AW-1:0]      ex_rd;
  logic                   ex_wb;
  logic                   ex_mem_read;
  logic [REG_AW-1:0]      mem_rd;
  logic                   mem_wb;
  logic [REG_AW-1:0]      wb_rd;
  logic                   wb_wb;
  logic                   branch_taken;
  logic                   interrupt;
  logic [1:0]             fwd_sel1;
  logic [1:0]             fwd_sel2;
  logic                   pc_hold;
  logic                   ifid_hold;
  logic                   idex_bubble;
  logic                   flush_ifid;
  logic                   int_push_pc;
  logic                   int_push_flags;
  logic                   int_vector_load;
  logic                   int_ret_branch;
  logic                   int_busy;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_wb, ex_mem_read, mem_rd, mem_wb, wb_rd, wb_wb, branch_taken, interrupt,
    input  fwd_sel1, fwd_sel2, pc_hold, ifid_hold, idex_bubble, flush_ifid,
           int_push_pc, int_push_flags, int_vector_load, int_ret_branch, int_busy,
           stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_wb, ex_mem_read, mem_rd, mem_wb, wb_rd, wb_wb, branch_taken, interrupt,
    output fwd_sel1, fwd_sel2, pc_hold, ifid_hold, idex_bubble, flush_ifid,
           int_push_pc, int_push_flags, int_vector_load, int_ret_branch, int_busy,
           stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard and sequencing controller for a 5-stage pipeline: EX operand
// forwarding, load-use stalls, branch flushes, a multi-cycle interrupt-entry
// sequence (drain, push PC, push flags, vector) and a saturating stall counter.
// Ports: clk, reset (sync, active-high), bus (pipeline_hazard_unit_if.slave).
// Hold/flush and forwarding outputs are combinational; strobes, int_busy,
// int_ret_branch and stall_count are registered.
module pipeline_hazard_unit #(
  parameter int unsigned REG_AW             = 3,
  parameter int unsigned DRAIN_CYCLES       = 3,
  parameter bit          ZERO_REG_HARDWIRED = 1'b0,
  parameter int unsigned STALL_CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_unit_if.slave  bus
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0]      DCNT_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRAIN, ST_PUSH_PC, ST_PUSH_FLAGS, ST_VECTOR
  } state_e;

  state_e                 state_q, state_d;
  logic [DCNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic                   pending_q, pending_d;
  logic                   queued_q, queued_d;
  logic                   ret_branch_q, ret_branch_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   int_prev_q;
  logic                   int_push_pc_q, int_push_flags_q, int_vector_load_q, int_busy_q;

  logic                   int_rise_c, lu_c;
  logic                   pc_hold_c, ifid_hold_c, idex_bubble_c, flush_ifid_c;
  logic [1:0]             fwd_sel1_c, fwd_sel2_c;

  // Register 0 optionally acts as a hardwired zero and never matches.
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !(ZERO_REG_HARDWIRED && (b == '0));
  endfunction

  // Memory-stage result is newer than writeback, so it wins.
  function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] rs);
    if (bus.mem_wb && reg_match(rs, bus.mem_rd)) return 2'b01;
    if (bus.wb_wb && reg_match(rs, bus.wb_rd))   return 2'b10;
    return 2'b00;
  endfunction

  // Forwarding selects and hazard detection.
  always_comb begin
    fwd_sel1_c = fwd_select(bus.ex_rs1);
    fwd_sel2_c = fwd_select(bus.ex_rs2);
    int_rise_c = bus.interrupt && !int_prev_q;
    lu_c       = bus.ex_mem_read && bus.ex_wb &&
                 ((bus.id_use_rs1 && reg_match(bus.id_rs1, bus.ex_rd)) ||
                  (bus.id_use_rs2 && reg_match(bus.id_rs2, bus.ex_rd)));
  end

  // Next-state and hold/flush outputs.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    pending_d     = pending_q | int_rise_c;
    queued_d      = queued_q;
    ret_branch_d  = ret_branch_q;
    stall_count_d = stall_count_q;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_bubble_c = 1'b0;
    flush_ifid_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.branch_taken) begin
          state_d = ST_IDLE;
        end else if (lu_c) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          if (stall_count_q != STALL_MAX) stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end else if (pending_d) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DCNT_LOAD;
        end
      end
      ST_DRAIN: begin
        pc_hold_c    = 1'b1;
        flush_ifid_c = 1'b1;
        // An edge while a request is in service waits behind it.
        if (int_rise_c) queued_d = 1'b1;
        // Return PC must be the branch target once a branch resolves here.
        if (bus.branch_taken) ret_branch_d = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_PUSH_PC;
        else                   drain_cnt_d = drain_cnt_q - DCNT_W'(1);
      end
      ST_PUSH_PC: begin
        pc_hold_c = 1'b1;
        if (int_rise_c) queued_d = 1'b1;
        state_d = ST_PUSH_FLAGS;
      end
      ST_PUSH_FLAGS: begin
        pc_hold_c = 1'b1;
        // Request in service retires; a queued or same-cycle edge stays pending.
        pending_d = int_rise_c | queued_q;
        queued_d  = 1'b0;
        state_d   = ST_VECTOR;
      end
      ST_VECTOR: begin
        ret_branch_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.branch_taken) begin
      flush_ifid_c  = 1'b1;
      idex_bubble_c = 1'b1;
      pc_hold_c     = 1'b0;
      ifid_hold_c   = 1'b0;
    end

    if (reset) begin
      pc_hold_c     = 1'b0;
      ifid_hold_c   = 1'b0;
      idex_bubble_c = 1'b0;
      flush_ifid_c  = 1'b0;
    end
  end

  // State register; interrupt level is sampled in reset so a held line is no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      drain_cnt_q       <= '0;
      pending_q         <= 1'b0;
      queued_q          <= 1'b0;
      ret_branch_q      <= 1'b0;
      stall_count_q     <= '0;
      int_prev_q        <= bus.interrupt;
      int_push_pc_q     <= 1'b0;
      int_push_flags_q  <= 1'b0;
      int_vector_load_q <= 1'b0;
      int_busy_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      drain_cnt_q       <= drain_cnt_d;
      pending_q         <= pending_d;
      queued_q          <= queued_d;
      ret_branch_q      <= ret_branch_d;
      stall_count_q     <= stall_count_d;
      int_prev_q        <= bus.interrupt;
      int_push_pc_q     <= (state_d == ST_PUSH_PC);
      int_push_flags_q  <= (state_d == ST_PUSH_FLAGS);
      int_vector_load_q <= (state_d == ST_VECTOR);
      int_busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign bus.fwd_sel1        = fwd_sel1_c;
  assign bus.fwd_sel2        = fwd_sel2_c;
  assign bus.pc_hold         = pc_hold_c;
  assign bus.ifid_hold       = ifid_hold_c;
  assign bus.idex_bubble     = idex_bubble_c;
  assign bus.flush_ifid      = flush_ifid_c;
  assign bus.int_push_pc     = int_push_pc_q;
  assign bus.int_push_flags  = int_push_flags_q;
  assign bus.int_vector_load = int_vector_load_q;
  assign bus.int_ret_branch  = ret_branch_q;
  assign bus.int_busy        = int_busy_q;
  assign bus.stall_count     = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (zero register normal with a
// 16-bit counter, zero register hardwired with a 2-bit counter) share stimulus
// and are compared every cycle against a phase-counter reference model.
module tb_pipeline_hazard_unit;
  localparam int unsigned AW = 3;
  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_wb, ex_mem_read, mem_wb, wb_wb;
  logic          branch_taken, interrupt;

  pipeline_hazard_unit_if #(.REG_AW(AW), .STALL_CNT_W(16)) if0 ();
  pipeline_hazard_unit_if #(.REG_AW(AW), .STALL_CNT_W(2))  if1 ();

  assign if0.id_rs1 = id_rs1;           assign if1.id_rs1 = id_rs1;
  assign if0.id_rs2 = id_rs2;           assign if1.id_rs2 = id_rs2;
  assign if0.id_use_rs1 = id_use_rs1;   assign if1.id_use_rs1 = id_use_rs1;
  assign if0.id_use_rs2 = id_use_rs2;   assign if1.id_use_rs2 = id_use_rs2;
  assign if0.ex_rs1 = ex_rs1;           assign if1.ex_rs1 = ex_rs1;
  assign if0.ex_rs2 = ex_rs2;           assign if1.ex_rs2 = ex_rs2;
  assign if0.ex_rd = ex_rd;             assign if1.ex_rd = ex_rd;
  assign if0.ex_wb = ex_wb;             assign if1.ex_wb = ex_wb;
  assign if0.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read;
  assign if0.mem_rd = mem_rd;           assign if1.mem_rd = mem_rd;
  assign if0.mem_wb = mem_wb;           assign if1.mem_wb = mem_wb;
  assign if0.wb_rd = wb_rd;             assign if1.wb_rd = wb_rd;
  assign if0.wb_wb = wb_wb;             assign if1.wb_wb = wb_wb;
  assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;
  assign if0.interrupt = interrupt;     assign if1.interrupt = interrupt;

  pipeline_hazard_unit #(.REG_AW(AW), .DRAIN_CYCLES(D), .ZERO_REG_HARDWIRED(1'b0),
                         .STALL_CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  pipeline_hazard_unit #(.REG_AW(AW), .DRAIN_CYCLES(D), .ZERO_REG_HARDWIRED(1'b1),
                         .STALL_CNT_W(2))  dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int checks = 0;
  int failures = 0;

  // Reference model: m_seq counts cycles since sequence start (0 = idle,
  // 1..D drain, D+1 push PC, D+2 push flags, D+3 vector); m_pend counts
  // requests not yet vectored (in service plus at most one waiting).
  int m_seq[2], m_pend[2], m_stall[2], m_max[2];
  bit m_ret[2], m_prev[2], m_zr[2];
  bit vec_seen, ret_seen;

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit mt(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !(m_zr[k] && (b == 0));
  endfunction

  function automatic logic [1:0] exp_fwd(input int k, input logic [AW-1:0] rs);
    if (mem_wb && mt(k, rs, mem_rd)) return 2'b01;
    if (wb_wb && mt(k, rs, wb_rd))   return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_lu(input int k);
    return ex_mem_read && ex_wb &&
           ((id_use_rs1 && mt(k, id_rs1, ex_rd)) || (id_use_rs2 && mt(k, id_rs2, ex_rd)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] o[13];
      logic [31:0] e[13];
      string nm[13] = '{"fwd1", "fwd2", "pc_hold", "ifid_hold", "idex_bubble", "flush_ifid",
                        "push_pc", "push_flags", "vector_load", "ret_branch", "busy",
                        "stall_count", "spare"};
      int s;
      s = m_seq[k];
      if (k == 0) begin
        o = '{32'(if0.fwd_sel1), 32'(if0.fwd_sel2), 32'(if0.pc_hold), 32'(if0.ifid_hold),
              32'(if0.idex_bubble), 32'(if0.flush_ifid), 32'(if0.int_push_pc),
              32'(if0.int_push_flags), 32'(if0.int_vector_load), 32'(if0.int_ret_branch),
              32'(if0.int_busy), 32'(if0.stall_count), 32'd0};
        vec_seen = if0.int_vector_load;
        ret_seen = if0.int_ret_branch;
      end else begin
        o = '{32'(if1.fwd_sel1), 32'(if1.fwd_sel2), 32'(if1.pc_hold), 32'(if1.ifid_hold),
              32'(if1.idex_bubble), 32'(if1.flush_ifid), 32'(if1.int_push_pc),
              32'(if1.int_push_flags), 32'(if1.int_vector_load), 32'(if1.int_ret_branch),
              32'(if1.int_busy), 32'(if1.stall_count), 32'd0};
      end
      e = '{default: 32'd0};
      e[0] = 32'(exp_fwd(k, ex_rs1));
      e[1] = 32'(exp_fwd(k, ex_rs2));
      if (!reset) begin
        if (branch_taken) begin
          e[4] = 1; e[5] = 1;
        end else if (s >= 1 && s <= D) begin
          e[2] = 1; e[5] = 1;
        end else if (s == D + 1 || s == D + 2) begin
          e[2] = 1;
        end else if (s == 0 && exp_lu(k)) begin
          e[2] = 1; e[3] = 1; e[4] = 1;
        end
      end
      e[6]  = 32'(s == D + 1);
      e[7]  = 32'(s == D + 2);
      e[8]  = 32'(s == D + 3);
      e[9]  = 32'(m_ret[k]);
      e[10] = 32'(s != 0);
      e[11] = 32'(m_stall[k]);
      for (int j = 0; j < 12; j++) chk($sformatf("dut%0d_%s", k, nm[j]), o[j], e[j]);
    end
  endtask

  task automatic model_advance();
    for (int k = 0; k < 2; k++) begin
      int r;
      if (reset) begin
        m_seq[k] = 0; m_pend[k] = 0; m_ret[k] = 0; m_stall[k] = 0;
        m_prev[k] = interrupt;
      end else begin
        r = (interrupt && !m_prev[k]) ? 1 : 0;
        if (m_seq[k] == 0) begin
          m_pend[k] = cap(m_pend[k] + r, 1);
          if (!branch_taken && exp_lu(k)) m_stall[k] = cap(m_stall[k] + 1, m_max[k]);
          if (m_pend[k] > 0 && !exp_lu(k) && !branch_taken) m_seq[k] = 1;
        end else if (m_seq[k] <= D) begin
          if (branch_taken) m_ret[k] = 1;
          m_pend[k] = cap(m_pend[k] + r, 2);
          m_seq[k]++;
        end else if (m_seq[k] == D + 1) begin
          m_pend[k] = cap(m_pend[k] + r, 2);
          m_seq[k]++;
        end else if (m_seq[k] == D + 2) begin
          m_pend[k] = cap(m_pend[k] - 1 + r, 1);
          m_seq[k]++;
        end else begin
          m_pend[k] = cap(m_pend[k] + r, 1);
          m_seq[k] = 0;
          m_ret[k] = 0;
        end
        m_prev[k] = interrupt;
      end
    end
  endtask

  // Check during the low phase, then let the edge happen and advance the model.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_wb = 0; ex_mem_read = 0; mem_wb = 0; wb_wb = 0;
    branch_taken = 0; interrupt = 0;
  endtask

  task automatic set_lu(input logic [AW-1:0] rd);
    ex_mem_read = 1; ex_wb = 1; ex_rd = rd; id_rs2 = rd; id_use_rs2 = 1;
  endtask

  initial begin
    int first_vec, second_vec, nvec;
    bit ret_at_vec;
    m_zr = '{1'b0, 1'b1};
    m_max = '{65535, 3};
    m_seq = '{0, 0}; m_pend = '{0, 0}; m_stall = '{0, 0}; m_ret = '{0, 0}; m_prev = '{0, 0};

    // Reset: first edge unchecked, second with reset still asserted.
    clear_inputs();
    reset = 1;
    @(posedge clk); model_advance(); @(negedge clk);
    cycle();
    reset = 0;

    // Forwarding priority.
    ex_rs1 = 3; mem_rd = 3; mem_wb = 1; wb_rd = 3; wb_wb = 1; ex_rs2 = 4;
    #1 chk("fwd_mem_priority", 32'(if0.fwd_sel1), 32'd1);
    chk("fwd_rs2_unmatched", 32'(if0.fwd_sel2), 32'd0);
    cycle();
    mem_wb = 0;
    #1 chk("fwd_wb_select", 32'(if0.fwd_sel1), 32'd2);
    cycle();

    // Load-use stall.
    clear_inputs(); set_lu(2);
    #1 chk("lu_pc_hold", 32'(if0.pc_hold), 32'd1);
    chk("lu_ifid_hold", 32'(if0.ifid_hold), 32'd1);
    chk("lu_idex_bubble", 32'(if0.idex_bubble), 32'd1);
    chk("lu_count_before", 32'(if0.stall_count), 32'd0);
    cycle();
    clear_inputs();
    #1 chk("lu_count_after", 32'(if0.stall_count), 32'd1);
    chk("lu_released", 32'(if0.pc_hold), 32'd0);
    cycle();

    // Register 0 only stalls when not hardwired.
    set_lu(0);
    #1 chk("zr0_stall", 32'(if0.pc_hold), 32'd1);
    chk("zr1_no_stall", 32'(if1.pc_hold), 32'd0);
    cycle();
    clear_inputs();
    #1 chk("zr1_count", 32'(if1.stall_count), 32'd1);
    cycle();

    // Branch overrides load-use.
    set_lu(2); branch_taken = 1;
    #1 chk("br_flush", 32'(if0.flush_ifid), 32'd1);
    chk("br_bubble", 32'(if0.idex_bubble), 32'd1);
    chk("br_pc_hold", 32'(if0.pc_hold), 32'd0);
    cycle();
    clear_inputs();
    #1 chk("br_count_unchanged", 32'(if0.stall_count), 32'd2);
    cycle();

    // Interrupt entry with a branch during drain.
    first_vec = -1; ret_at_vec = 0;
    for (int i = 0; i < 12; i++) begin
      clear_inputs(); interrupt = (i == 0); branch_taken = (i == 2);
      cycle();
      if (vec_seen && first_vec < 0) begin first_vec = i; ret_at_vec = ret_seen; end
    end
    chk("int_latency", 32'(first_vec), 32'(D + 3));
    chk("int_ret_branch_at_vector", 32'(ret_at_vec), 32'd1);

    // Second edge during push-PC queues a repeat sequence.
    first_vec = -1; second_vec = -1; ret_at_vec = 1;
    for (int i = 0; i < 20; i++) begin
      clear_inputs(); interrupt = (i == 0 || i == D + 1);
      cycle();
      if (vec_seen) begin
        if (first_vec < 0) begin first_vec = i; ret_at_vec = ret_seen; end
        else if (second_vec < 0) second_vec = i;
      end
    end
    chk("int2_first_vector", 32'(first_vec), 32'(D + 3));
    chk("int2_ret_cleared", 32'(ret_at_vec), 32'd0);
    chk("int2_second_vector", 32'(second_vec), 32'(2 * D + 7));

    // Reset during push-flags aborts and discards a queued request.
    nvec = 0;
    for (int i = 0; i < 14; i++) begin
      clear_inputs(); interrupt = (i == 0 || i == D); reset = (i == D + 2);
      cycle();
      if (vec_seen) nvec++;
    end
    reset = 0;
    chk("int_reset_no_vector", 32'(nvec), 32'd0);

    // Counter saturation.
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_lu(3);
      cycle();
    end
    clear_inputs();
    #1 chk("sat_w2", 32'(if1.stall_count), 32'd3);
    chk("sat_w16", 32'(if0.stall_count), 32'd5);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3));  mem_rd = AW'($urandom_range(0, 3));
      wb_rd = AW'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      mem_wb = 1'($urandom); wb_wb = 1'($urandom);
      ex_wb = 1'($urandom); ex_mem_read = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) interrupt = ~interrupt;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
